// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   - parity mode constants used by the PARITY parameter
//   - receive FSM state encoding
//   - div_calc: clocks per bit for a given clock frequency and baud rate
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // The ST_ prefix keeps the state names clear of the PARITY module parameter.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic int div_calc(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART byte receiver: 2-FF input synchroniser, bit timing and receive FSM.
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   uart_rxd      - asynchronous serial input, idle high
//   rx_byte       - received byte, meaningful in the cycle byte_done is high
//   byte_done     - one-cycle strobe: good byte completed (mid-stop sample)
//   frame_err     - one-cycle strobe: stop bit sampled low
//   parity_err    - one-cycle strobe: parity mismatch on the finished frame
//   idle          - FSM is in IDLE (no frame in progress)
// All strobes are combinational and coincide with the mid-stop sample cycle.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int PARITY   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       idle
);

  localparam int          DIV     = div_calc(CLK_FREQ, BAUD);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(DIV - 1);
  // Data XOR parity bit must equal this for a good frame.
  localparam logic        PAR_TARGET = (PARITY == PARITY_ODD);

  logic        sync1_reg, sync2_reg;
  logic        rxd_s;
  rx_state_e   state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  bit_reg, bit_next;
  logic [7:0]  shift_reg, shift_next;
  logic        par_err_reg, par_err_next;

  assign rxd_s = sync2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      par_err_reg <= 1'b0;
    end else begin
      sync1_reg   <= uart_rxd;
      sync2_reg   <= sync1_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      par_err_reg <= par_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_next     = bit_reg;
    shift_next   = shift_reg;
    par_err_next = par_err_reg;
    byte_done    = 1'b0;
    frame_err    = 1'b0;
    parity_err   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!rxd_s) begin
          state_next = ST_START;
          cnt_next   = '0;
          bit_next   = '0;
        end
      end
      ST_START: begin
        // Half a bit in: a line that is high again was a glitch.
        if (cnt_reg == HALF_M1) begin
          cnt_next = '0;
          if (!rxd_s) begin
            state_next   = ST_DATA;
            par_err_next = 1'b0;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next   = '0;
          shift_next = {rxd_s, shift_reg[7:1]};  // LSB arrives first
          if (bit_reg == 3'd7) begin
            state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_PARITY: begin
        if (cnt_reg == FULL_M1) begin
          cnt_next     = '0;
          state_next   = ST_STOP;
          par_err_next = ((^shift_reg) ^ rxd_s) != PAR_TARGET;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_STOP: begin
        // Leave right after the mid-stop sample so a following start bit
        // that begins at the end of this stop bit is not missed.
        if (cnt_reg == FULL_M1) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
          frame_err  = !rxd_s;
          parity_err = par_err_reg;
          byte_done  = rxd_s && !par_err_reg;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rx_byte = shift_reg;
  assign idle    = (state_reg == ST_IDLE);

endmodule

// File: rtl/uart_rx_word.sv
// UART receiver with word assembler and valid/ready output.
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   uart_rxd       - asynchronous serial input, idle high
//   word_data      - assembled WORD_BYTES*8-bit word, stable while word_valid
//   word_valid     - word available in the output slot
//   word_ready     - consumer accepts when word_valid && word_ready
//   frame_err      - one-cycle pulse: stop bit sampled low
//   parity_err     - one-cycle pulse: parity mismatch
//   overrun        - one-cycle pulse: completed word dropped (slot still full)
//   timeout_abort  - one-cycle pulse: partial word discarded after idle time
// Any errored byte drops the partial word so assembly resyncs on the next byte.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int WORD_BYTES   = 8,
  parameter int PARITY       = 0,
  parameter int MSB_FIRST    = 0,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_rxd,
  output logic [WORD_BYTES*8-1:0] word_data,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    frame_err,
  output logic                    parity_err,
  output logic                    overrun,
  output logic                    timeout_abort
);

  localparam int DIV    = div_calc(CLK_FREQ, BAUD);
  localparam int TO_CYC = TIMEOUT_BITS * DIV;

  logic [7:0] rx_byte;
  logic       rx_byte_done, rx_frame_err, rx_parity_err, rx_idle;

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .PARITY   (PARITY)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .uart_rxd   (uart_rxd),
    .rx_byte    (rx_byte),
    .byte_done  (rx_byte_done),
    .frame_err  (rx_frame_err),
    .parity_err (rx_parity_err),
    .idle       (rx_idle)
  );

  logic [4:0]              count_reg, count_next;
  logic [4:0]              slot_idx;
  logic [31:0]             idle_cnt_reg, idle_cnt_next;
  logic                    timeout_hit;
  logic                    word_complete;
  logic [WORD_BYTES*8-1:0] word_assembled;
  logic [WORD_BYTES*8-1:0] word_data_reg, word_data_next;
  logic                    word_valid_reg, word_valid_next;
  logic                    overrun_reg, overrun_next;
  logic                    timeout_reg, timeout_next;
  logic                    frame_err_reg, parity_err_reg;

  always_comb begin
    slot_idx = count_reg;
    if (MSB_FIRST != 0) slot_idx = 5'(WORD_BYTES - 1) - count_reg;
  end

  // Byte slots. word_assembled already includes the byte arriving this
  // cycle so the final byte can go straight into the output slot.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_slot
      logic [7:0] slot_reg;
      logic       hit;
      assign hit = rx_byte_done && (slot_idx == 5'(gi));
      assign word_assembled[gi*8 +: 8] = hit ? rx_byte : slot_reg;
      always_ff @(posedge clk) begin
        if (rst)      slot_reg <= '0;
        else if (hit) slot_reg <= rx_byte;
      end
    end
  endgenerate

  assign word_complete = rx_byte_done && (count_reg == 5'(WORD_BYTES - 1));
  assign timeout_hit   = rx_idle && (count_reg != 5'd0) &&
                         (idle_cnt_reg == 32'(TO_CYC - 1));

  always_comb begin
    count_next      = count_reg;
    word_data_next  = word_data_reg;
    word_valid_next = word_valid_reg;
    overrun_next    = 1'b0;
    timeout_next    = 1'b0;
    idle_cnt_next   = '0;

    if (word_valid_reg && word_ready) word_valid_next = 1'b0;

    if (rx_frame_err || rx_parity_err) begin
      count_next = '0;
    end else if (word_complete) begin
      count_next = '0;
      // Accept when the slot is free or is being drained this same cycle.
      if (!word_valid_reg || word_ready) begin
        word_data_next  = word_assembled;
        word_valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (rx_byte_done) begin
      count_next = count_reg + 5'd1;
    end else if (timeout_hit) begin
      count_next   = '0;
      timeout_next = 1'b1;
    end

    // Idle timer only runs between bytes of a partial word.
    if (rx_idle && (count_reg != 5'd0) && !timeout_hit)
      idle_cnt_next = idle_cnt_reg + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg      <= '0;
      idle_cnt_reg   <= '0;
      word_data_reg  <= '0;
      word_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      timeout_reg    <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      count_reg      <= count_next;
      idle_cnt_reg   <= idle_cnt_next;
      word_data_reg  <= word_data_next;
      word_valid_reg <= word_valid_next;
      overrun_reg    <= overrun_next;
      timeout_reg    <= timeout_next;
      frame_err_reg  <= rx_frame_err;
      parity_err_reg <= rx_parity_err;
    end
  end

  assign word_data     = word_data_reg;
  assign word_valid    = word_valid_reg;
  assign overrun       = overrun_reg;
  assign timeout_abort = timeout_reg;
  assign frame_err     = frame_err_reg;
  assign parity_err    = parity_err_reg;

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word. A short bit period (DIV=16) keeps the run
// small; timing relations scale with DIV. Three instances: LSB-first/no parity
// (main), MSB-first sharing the main line, and even parity on its own line.
module tb_uart_rx_word;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / BAUD;  // 16
  localparam int TO_BITS  = 20;
  localparam int TO_CYC   = TO_BITS * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic rxd_par = 1'b1;
  logic ready = 1'b1;
  logic ready_msb = 1'b1;
  logic ready_par = 1'b1;

  logic [63:0] wd, wd_msb, wd_par;
  logic wv, fe, pe, ov, to;
  logic wv_msb, fe_msb, pe_msb, ov_msb, to_msb;
  logic wv_par, fe_par, pe_par, ov_par, to_par;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_word #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .WORD_BYTES(8), .PARITY(0),
                 .MSB_FIRST(0), .TIMEOUT_BITS(TO_BITS)) u_main (
    .clk(clk), .rst(rst), .uart_rxd(rxd), .word_data(wd), .word_valid(wv),
    .word_ready(ready), .frame_err(fe), .parity_err(pe), .overrun(ov),
    .timeout_abort(to));

  uart_rx_word #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .WORD_BYTES(8), .PARITY(0),
                 .MSB_FIRST(1), .TIMEOUT_BITS(TO_BITS)) u_msb (
    .clk(clk), .rst(rst), .uart_rxd(rxd), .word_data(wd_msb), .word_valid(wv_msb),
    .word_ready(ready_msb), .frame_err(fe_msb), .parity_err(pe_msb), .overrun(ov_msb),
    .timeout_abort(to_msb));

  uart_rx_word #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .WORD_BYTES(8), .PARITY(2),
                 .MSB_FIRST(0), .TIMEOUT_BITS(TO_BITS)) u_par (
    .clk(clk), .rst(rst), .uart_rxd(rxd_par), .word_data(wd_par), .word_valid(wv_par),
    .word_ready(ready_par), .frame_err(fe_par), .parity_err(pe_par), .overrun(ov_par),
    .timeout_abort(to_par));

  // Event monitors (negedge sampling, away from the active edge).
  int cyc = 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, to_cnt = 0, wv_cnt = 0, to_cyc = 0;
  int wv_msb_cnt = 0, wv_par_cnt = 0, pe_par_cnt = 0;
  logic [63:0] last_word = '0, last_msb = '0, last_par = '0;
  logic wv_prev = 1'b0, wv_msb_prev = 1'b0, wv_par_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fe) fe_cnt++;
    if (pe) pe_cnt++;
    if (ov) ov_cnt++;
    if (to) begin to_cnt++; to_cyc = cyc; end
    if (wv && !wv_prev) begin wv_cnt++; last_word = wd; end
    wv_prev = wv;
    if (wv_msb && !wv_msb_prev) begin wv_msb_cnt++; last_msb = wd_msb; end
    wv_msb_prev = wv_msb;
    if (wv_par && !wv_par_prev) begin wv_par_cnt++; last_par = wd_par; end
    wv_par_prev = wv_par;
    if (pe_par) pe_par_cnt++;
  end

  task automatic set_line(input int ln, input logic v);
    if (ln == 0) rxd = v;
    else         rxd_par = v;
  endtask

  // One frame: start, 8 data LSB first, optional parity, stop.
  task automatic send_frame(input int ln, input logic [7:0] d, input logic stop_v,
                            input logic par_en, input logic par_v);
    set_line(ln, 1'b0);
    repeat (DIV) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      set_line(ln, d[b]);
      repeat (DIV) @(negedge clk);
    end
    if (par_en) begin
      set_line(ln, par_v);
      repeat (DIV) @(negedge clk);
    end
    set_line(ln, stop_v);
    repeat (DIV) @(negedge clk);
    set_line(ln, 1'b1);
  endtask

  task automatic send_word_main(input logic [7:0] base);
    for (int i = 0; i < 8; i++) send_frame(0, base + 8'(i), 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (wv !== 1'b0) begin errors++; $display("FAIL reset_word_valid: got %b expected 0", wv); end
    checks++; if (wd !== 64'h0) begin errors++; $display("FAIL reset_word_data: got %h expected 0", wd); end
    checks++; if (fe !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", fe); end
    checks++; if (pe !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", pe); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", ov); end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", to); end
    rst = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    $display("reset: done");
  endtask

  task automatic test_word_assembly();
    int wv0 = wv_cnt, wm0 = wv_msb_cnt, e0 = fe_cnt + pe_cnt + ov_cnt + to_cnt;
    send_word_main(8'h01);
    checks++; if (wv_cnt - wv0 !== 1) begin errors++; $display("FAIL word_count: got %0d expected 1", wv_cnt - wv0); end
    checks++; if (last_word !== 64'h0807060504030201) begin errors++; $display("FAIL word_data_lsb: got %h expected 0807060504030201", last_word); end
    checks++; if (wv_msb_cnt - wm0 !== 1) begin errors++; $display("FAIL word_count_msb: got %0d expected 1", wv_msb_cnt - wm0); end
    checks++; if (last_msb !== 64'h0102030405060708) begin errors++; $display("FAIL word_data_msb: got %h expected 0102030405060708", last_msb); end
    checks++; if (fe_cnt + pe_cnt + ov_cnt + to_cnt - e0 !== 0) begin errors++; $display("FAIL word_no_errors: got %0d expected 0", fe_cnt + pe_cnt + ov_cnt + to_cnt - e0); end
    $display("word_assembly: lsb=%h msb=%h", last_word, last_msb);
  endtask

  task automatic test_back_to_back_overrun();
    int wv0, ov0;
    ready = 1'b0;
    wv0 = wv_cnt; ov0 = ov_cnt;
    send_word_main(8'h11);
    checks++; if (wv !== 1'b1) begin errors++; $display("FAIL bp_valid_high: got %b expected 1", wv); end
    checks++; if (wd !== 64'h1817161514131211) begin errors++; $display("FAIL bp_data: got %h expected 1817161514131211", wd); end
    send_word_main(8'h21);
    checks++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL bp_overrun_count: got %0d expected 1", ov_cnt - ov0); end
    checks++; if (wv !== 1'b1 || wv_cnt - wv0 !== 1) begin errors++; $display("FAIL bp_valid_held: got valid=%b rises=%0d expected 1/1", wv, wv_cnt - wv0); end
    checks++; if (wd !== 64'h1817161514131211) begin errors++; $display("FAIL bp_data_held: got %h expected 1817161514131211", wd); end
    ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (wv !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b expected 0", wv); end
    @(negedge clk);
    $display("back_to_back_overrun: overruns=%0d", ov_cnt - ov0);
  endtask

  task automatic test_glitch();
    int e0 = fe_cnt + pe_cnt + ov_cnt, wv0 = wv_cnt;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    checks++; if (fe_cnt + pe_cnt + ov_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_no_errors: got %0d expected 0", fe_cnt + pe_cnt + ov_cnt - e0); end
    checks++; if (wv_cnt - wv0 !== 0) begin errors++; $display("FAIL glitch_no_word: got %0d expected 0", wv_cnt - wv0); end
    send_word_main(8'h31);
    checks++; if (last_word !== 64'h3837363534333231) begin errors++; $display("FAIL glitch_next_word: got %h expected 3837363534333231", last_word); end
    $display("glitch: word=%h", last_word);
  endtask

  task automatic test_frame_error();
    int fe0 = fe_cnt, wv0 = wv_cnt;
    send_frame(0, 8'hA0, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'hA1, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'hA2, 1'b0, 1'b0, 1'b0);
    repeat (DIV) @(negedge clk);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL frame_err_count: got %0d expected 1", fe_cnt - fe0); end
    send_word_main(8'hA0);
    checks++; if (wv_cnt - wv0 !== 1) begin errors++; $display("FAIL frame_word_count: got %0d expected 1", wv_cnt - wv0); end
    checks++; if (last_word !== 64'hA7A6A5A4A3A2A1A0) begin errors++; $display("FAIL frame_resync_word: got %h expected A7A6A5A4A3A2A1A0", last_word); end
    $display("frame_error: word=%h", last_word);
  endtask

  task automatic test_parity_error();
    int pe0 = pe_par_cnt, wv0 = wv_par_cnt;
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);  // even parity of 0x03 is 0
    repeat (DIV) @(negedge clk);
    checks++; if (pe_par_cnt - pe0 !== 1) begin errors++; $display("FAIL parity_err_count: got %0d expected 1", pe_par_cnt - pe0); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      d = 8'h10 + 8'(i);
      send_frame(1, d, 1'b1, 1'b1, ^d);
    end
    repeat (4) @(negedge clk);
    checks++; if (wv_par_cnt - wv0 !== 1) begin errors++; $display("FAIL parity_word_count: got %0d expected 1", wv_par_cnt - wv0); end
    checks++; if (last_par !== 64'h1716151413121110) begin errors++; $display("FAIL parity_word: got %h expected 1716151413121110", last_par); end
    checks++; if (pe_par_cnt - pe0 !== 1) begin errors++; $display("FAIL parity_good_bytes: got %0d expected 1", pe_par_cnt - pe0); end
    $display("parity_error: word=%h", last_par);
  endtask

  task automatic test_timeout();
    int to0, t0, waited;
    to0 = to_cnt;
    send_frame(0, 8'h41, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'h42, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'h43, 1'b1, 1'b0, 1'b0);
    t0 = cyc;
    waited = 0;
    while (to_cnt == to0 && waited < 25 * DIV) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (to_cnt - to0 !== 1) begin errors++; $display("FAIL timeout_pulse: got %0d expected 1", to_cnt - to0); end
    // Last stop sample falls ~5 cycles before the stop bit ends.
    checks++; if (to_cyc - t0 < TO_CYC - 10 || to_cyc - t0 > TO_CYC + 2) begin errors++; $display("FAIL timeout_delay: got %0d expected about %0d", to_cyc - t0, TO_CYC - 5); end
    send_word_main(8'h51);
    checks++; if (last_word !== 64'h5857565554535251) begin errors++; $display("FAIL timeout_next_word: got %h expected 5857565554535251", last_word); end
    $display("timeout: delay=%0d word=%h", to_cyc - t0, last_word);
  endtask

  task automatic test_reset_mid();
    int e0, wv0;
    for (int i = 0; i < 4; i++) send_frame(0, 8'h61 + 8'(i), 1'b1, 1'b0, 1'b0);
    rxd = 1'b0;  // start of byte 5, then three data bits
    repeat (DIV) @(negedge clk);
    rxd = 1'b1; repeat (DIV) @(negedge clk);
    rxd = 1'b0; repeat (2 * DIV) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({wv, fe, pe, ov, to} !== 5'b0) begin errors++; $display("FAIL midrst_outputs: got %b expected 00000", {wv, fe, pe, ov, to}); end
    checks++; if (wd !== 64'h0) begin errors++; $display("FAIL midrst_data: got %h expected 0", wd); end
    rst = 1'b0;
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    e0 = fe_cnt + pe_cnt + ov_cnt + to_cnt;
    wv0 = wv_cnt;
    send_word_main(8'h71);
    checks++; if (wv_cnt - wv0 !== 1) begin errors++; $display("FAIL midrst_word_count: got %0d expected 1", wv_cnt - wv0); end
    checks++; if (last_word !== 64'h7877767574737271) begin errors++; $display("FAIL midrst_word: got %h expected 7877767574737271", last_word); end
    checks++; if (fe_cnt + pe_cnt + ov_cnt + to_cnt - e0 !== 0) begin errors++; $display("FAIL midrst_no_errors: got %0d expected 0", fe_cnt + pe_cnt + ov_cnt + to_cnt - e0); end
    $display("reset_mid: word=%h", last_word);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_word_assembly();
    test_back_to_back_overrun();
    test_glitch();
    test_frame_error();
    test_parity_error();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- Parametrised UART receiver with a word assembler.
- Deserialises 8-bit UART frames (optional parity) and packs WORD_BYTES consecutive bytes into one parallel word.
- Presents each word on a valid/ready handshake, with error, overrun and inter-byte-timeout reporting.
- Sits between the board UART pin and downstream parallel consumers as the generalised, flow-controlled receive path.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate. DIV = CLK_FREQ/BAUD (integer divide) clocks per bit.
- WORD_BYTES, 8: bytes per output word, range 1..16.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- MSB_FIRST, 0: 0 = first received byte lands in word_data[7:0]; 1 = first byte lands in the top byte.
- TIMEOUT_BITS, 20: idle bit-times allowed between bytes of a partial word before it is discarded.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- uart_rxd, input, 1: asynchronous serial input, idle high.
- word_data, output, WORD_BYTES*8: assembled word, stable while word_valid=1.
- word_valid, output, 1: word available.
- word_ready, input, 1: consumer accepts the word when word_valid && word_ready.
- frame_err, output, 1: one-cycle pulse when the stop bit is sampled low.
- parity_err, output, 1: one-cycle pulse on parity mismatch.
- overrun, output, 1: one-cycle pulse when a completed word is dropped.
- timeout_abort, output, 1: one-cycle pulse when a partial word is discarded by timeout.

Behaviour:
- Reset:
  - All outputs 0.
  - Input synchroniser stages preset to 1.
  - FSM returns to IDLE; byte count 0; output slot empty.
  - Reset mid-frame or mid-word discards all partial state.
- Input: uart_rxd passes through a 2-FF synchroniser; all sampling uses the synchronised value.
- Receive FSM:
  - IDLE: a low on the synchronised line enters START, bit counter cleared.
  - START: wait DIV/2 cycles, then resample. Low → DATA. High → IDLE (glitch rejected silently).
  - DATA: sample every DIV cycles, 8 samples, LSB first into a shift register.
  - PARITY (only if PARITY≠0): one sample at +DIV; mismatch sets the byte error flag.
  - STOP: sample at +DIV.
    - Low → frame_err pulse.
    - Parity mismatch → parity_err pulse.
    - Both faults → both pulses in the same cycle.
    - Good byte → byte_done pulse.
    - Return to IDLE immediately after the mid-stop sample, so back-to-back frames are accepted.
- Assembler:
  - On byte_done, the byte is written into slot count (MSB_FIRST selects slot order) and count increments.
  - On an errored byte, the byte is dropped and count resets to 0 (word resync).
  - When count reaches WORD_BYTES:
    - Slot empty, or being emptied this cycle (word_valid && word_ready): transfer the word; word_valid=1 on the next clock.
    - Otherwise: pulse overrun, discard the new word, keep the held word unchanged.
    - In both cases count returns to 0.
- Latency: word_valid rises 1 cycle after the stop-bit sample of the last byte.
- Handshake:
  - word_valid, once high, holds with word_data unchanged until the cycle after word_valid && word_ready.
  - word_data holds its last value after acceptance.
- Timeout:
  - An idle counter runs only while count>0 and the FSM is in IDLE; it clears on any start bit.
  - At TIMEOUT_BITS*DIV cycles: pulse timeout_abort and set count=0.
  - Timeout never affects a word already in the output slot.
- Simultaneous events:
  - A word completing while the held word is accepted in the same cycle is a legal transfer, not an overrun.
  - rst has priority over everything.

Decomposition:
- Shared package uart_pkg:
  - PARITY_NONE/ODD/EVEN constants.
  - Receive state enum IDLE/START/DATA/PARITY/STOP.
  - div_calc function returning CLK_FREQ/BAUD.
- Sub-module uart_rx_core: synchroniser, bit timing, receive FSM. Outputs byte, byte_done, frame_err, parity_err, idle.
- uart_rx_word instantiates uart_rx_core and holds the assembler, output slot, overrun logic and timeout.

Test Plan:
- Bench settings: CLK_FREQ=50 MHz, BAUD=115200 (DIV=434), WORD_BYTES=8, word_ready=1.
- Word assembly: send bytes 0x01..0x08 → exactly one word_valid pulse, word_data=64'h0807060504030201. With MSB_FIRST=1 → 64'h0102030405060708.
- Backpressure and overrun: word_ready=0, send 0x11..0x18 then 0x21..0x28 → word_valid held, data =64'h1817161514131211, overrun pulses once at the second word's stop bit. Raise word_ready → word_valid drops the next cycle.
- Glitch rejection: drive uart_rxd low for 100 cycles → no byte, no error pulses, count stays 0.
- Frame and parity errors: stop bit low on byte 3 → frame_err pulse, partial word discarded; then 0xA0..0xA7 → word 64'hA7A6A5A4A3A2A1A0. With PARITY=2, send 0x03 with parity bit 1 → parity_err pulse, byte dropped.
- Timeout: send 3 bytes, idle 25 bit-times → timeout_abort at 20*434 cycles after the last stop sample; following 8 bytes form a correct word.
- Reset mid-operation: assert rst for 1 cycle during byte 5 → all outputs 0; the next full 8-byte sequence yields a correct word with no error pulses.
